// File: rtl/elastic_pipe_reg_pkg.sv
// rtl/elastic_pipe_reg_pkg.sv - shared types, limits and width helper for the elastic pipeline register
//
// Purpose: common definitions imported by the elastic pipeline interface, slot and top.
// Ports:   none (package).
package elastic_pipe_reg_pkg;

  // Deepest pipe this block is intended to be instantiated with.
  localparam int PIPE_DEPTH_MAX = 64;

  // Payload width of the default (32-bit) stage bundle.
  localparam int PIPE_DATA_W_DEFAULT = 32;

  // One pipeline slot: valid bit plus the packed stage bundle.
  typedef struct packed {
    logic                           v;
    logic [PIPE_DATA_W_DEFAULT-1:0] d;
  } pipe_slot_t;

  // Occupancy counter width: counts 0..depth+1 (all stages plus the skid slot).
  function automatic int pipe_cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_if.sv
// rtl/elastic_pipe_reg_if.sv - handshake bundle between an upstream stage, the elastic pipe and a downstream stage
//
// Purpose: groups the input/output valid-ready-data handshakes, flush and occupancy count.
// Ports (signals):
//   in_valid/in_ready/in_data    upstream beat handshake
//   out_valid/out_ready/out_data downstream beat handshake
//   flush                        discard every held beat
//   count                        beats held (stages + skid)
// Modports: master drives the pipe (upstream/downstream/hazard side), slave is the pipe itself.
interface elastic_pipe_reg_if
  import elastic_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = pipe_cnt_w(DEPTH)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/elastic_pipe_reg_pipe_slot.sv
// rtl/elastic_pipe_reg_pipe_slot.sv - one valid+data register with load/clear/hold control
//
// Purpose: storage element for one pipeline stage or the input skid slot.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset (clears valid and data)
//   load  in  capture din and set valid
//   clr   in  clear valid only, data left as is; wins over load
//   din   in  payload to capture
//   v     out held valid bit
//   d     out held payload
module pipe_slot
  import elastic_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              v,
  output logic [DATA_W-1:0] d
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      // Data is deliberately not touched: a cleared slot keeps its stale payload.
      v <= 1'b0;
    end else if (load) begin
      v <= 1'b1;
      d <= din;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - DEPTH-stage elastic pipeline register with skid slot, bubble collapse and flush
//
// Purpose: valid/ready pipeline between core stages; stalls collapse bubbles, flush drops all held beats,
//          a one-entry skid slot keeps in_ready a registered signal.
// Ports:
//   clk  in     clock, rising edge
//   rst  in     asynchronous active-low reset
//   bus  slave  in_valid/in_ready/in_data, out_valid/out_ready/out_data, flush, count
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = pipe_cnt_w(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  elastic_pipe_reg_if.slave bus
);

  // Slots 0..DEPTH-1 are the stages (DEPTH-1 drives the output); slot DEPTH is the skid.
  localparam int SKID = DEPTH;

  logic [DEPTH:0]    slot_v;
  logic [DEPTH:0]    slot_load;
  logic [DEPTH:0]    slot_clr;
  logic [DATA_W-1:0] slot_d   [DEPTH+1];
  logic [DATA_W-1:0] slot_din [DEPTH+1];

  logic [DEPTH-1:0]  advance;
  logic [DEPTH-1:0]  can_load;
  logic              down_ok;
  logic              skid_v;
  logic              in_xfer;
  logic              out_xfer;
  logic [CNT_W-1:0]  count_q;

  assign skid_v   = slot_v[SKID];
  assign in_xfer  = bus.in_valid & ~skid_v;
  assign out_xfer = slot_v[DEPTH-1] & bus.out_ready;

  // Ready chain walks from the output back to stage 0; down_ok carries
  // "the stage after this one can take a beat" to the next lower index.
  always_comb begin
    advance  = '0;
    can_load = '0;
    down_ok  = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      advance[i]  = slot_v[i] & down_ok;
      can_load[i] = ~slot_v[i] | advance[i];
      down_ok     = can_load[i];
    end
  end

  // Slot controls. A stage that advances without being refilled drops its
  // valid; an empty stage always pulls from its predecessor, so gaps close
  // up even while the output is stalled. Flush clears every valid bit.
  always_comb begin
    slot_load = '0;
    slot_clr  = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      slot_din[i] = '0;
    end

    // Stage 0: the skid beat is older than anything on in_data, so it goes
    // first and no new input is accepted in that cycle (in_ready is low).
    if (skid_v) begin
      slot_load[0] = can_load[0];
      slot_din[0]  = slot_d[SKID];
    end else begin
      slot_load[0] = can_load[0] & in_xfer;
      slot_din[0]  = bus.in_data;
    end
    slot_clr[0] = bus.flush | (advance[0] & ~slot_load[0]);

    for (int i = 1; i < DEPTH; i++) begin
      slot_load[i] = can_load[i] & slot_v[i-1];
      slot_din[i]  = slot_d[i-1];
      slot_clr[i]  = bus.flush | (advance[i] & ~slot_load[i]);
    end

    // Skid catches a beat accepted while stage 0 cannot take it.
    slot_load[SKID] = in_xfer & ~can_load[0];
    slot_din[SKID]  = bus.in_data;
    slot_clr[SKID]  = bus.flush | (skid_v & can_load[0]);
  end

  for (genvar g = 0; g <= DEPTH; g++) begin : g_slot
    pipe_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (slot_load[g]),
      .clr  (slot_clr[g]),
      .din  (slot_din[g]),
      .v    (slot_v[g]),
      .d    (slot_d[g])
    );
  end

  // Cannot wrap: input is refused whenever the skid is full, capping count at DEPTH+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = slot_v[DEPTH-1];
  assign bus.out_data  = slot_d[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - scoreboard bench for elastic_pipe_reg at DEPTH 2, 3 and 4
module tb_elastic_pipe_reg;
  import elastic_pipe_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  elastic_pipe_reg_if #(.DATA_W(32), .DEPTH(2)) if2 ();
  elastic_pipe_reg_if #(.DATA_W(32), .DEPTH(3)) if3 ();
  elastic_pipe_reg_if #(.DATA_W(32), .DEPTH(4)) if4 ();

  elastic_pipe_reg #(.DATA_W(32), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  elastic_pipe_reg #(.DATA_W(32), .DEPTH(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
  elastic_pipe_reg #(.DATA_W(32), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0; if2.flush = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b0; if3.flush = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0; if4.flush = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_all();
    if2.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if2.in_data = 32'h100 + k;
      step();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", if2.in_ready); end
    n_checks++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if2.out_valid); end
    n_checks++; if (if2.count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", if2.count); end
    n_checks++; if (if2.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", if2.out_data); end
    @(negedge clk);
    rst = 1'b1;
    if2.in_valid = 1'b0;
    step();
    n_checks++; if (if2.count !== 2'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d expected 0", if2.count); end
  endtask

  task automatic test_latency();
    idle_all();
    if3.out_ready = 1'b1;
    if3.in_valid  = 1'b1;
    if3.in_data   = 32'hA5A5_0001;
    n_checks++; if (if3.in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b expected 1", if3.in_ready); end
    sb.push_back(if3.in_data);
    step();
    if3.in_valid = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      n_checks++;
      if (if3.out_valid !== (cyc == 3)) begin n_fail++; $display("FAIL lat_out_valid: cycle %0d got %b expected %b", cyc, if3.out_valid, (cyc == 3)); end
      if (if3.out_valid && if3.out_ready && sb.size() > 0) begin
        exp_d = sb.pop_front();
        n_checks++; if (if3.out_data !== exp_d) begin n_fail++; $display("FAIL lat_data: got %h expected %h", if3.out_data, exp_d); end
      end
      step();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL lat_lost: %0d beats left expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int   pops;
    logic xin;
    idle_all();
    if2.in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if2.in_data = k;
      n_checks++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: beat %0d in_ready %b expected 1", k, if2.in_ready); end
      sb.push_back(if2.in_data);
      step();
    end
    n_checks++; if (if2.count !== 2'd3) begin n_fail++; $display("FAIL bp_count_full: got %0d expected 3", if2.count); end
    n_checks++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", if2.in_ready); end
    if2.in_data = 32'h4;
    step();
    step();
    n_checks++; if (if2.count !== 2'd3 || if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: count %0d in_ready %b expected 3 and 0", if2.count, if2.in_ready); end
    n_checks++; if (if2.out_data !== 32'h1) begin n_fail++; $display("FAIL bp_hold_data: got %h expected 1", if2.out_data); end
    if2.out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      xin = if2.in_valid && if2.in_ready;
      if (xin) sb.push_back(if2.in_data);
      if (if2.out_valid) begin
        pops++;
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_extra: got beat %h expected none", if2.out_data);
        end else begin
          exp_d = sb.pop_front();
          n_checks++; if (if2.out_data !== exp_d) begin n_fail++; $display("FAIL bp_order: got %h expected %h", if2.out_data, exp_d); end
        end
      end
      step();
      if (xin) if2.in_valid = 1'b0;
    end
    n_checks++; if (pops != 4) begin n_fail++; $display("FAIL bp_drain: got %0d beats expected 4", pops); end
  endtask

  task automatic test_bubble();
    idle_all();
    if4.in_valid = 1'b1; if4.in_data = 32'h10; sb.push_back(32'h10);
    step();
    if4.in_valid = 1'b0;
    step();
    step();
    if4.in_valid = 1'b1; if4.in_data = 32'h20; sb.push_back(32'h20);
    step();
    if4.in_valid = 1'b0;
    repeat (6) step();
    n_checks++; if (if4.count !== 3'd2) begin n_fail++; $display("FAIL bub_count: got %0d expected 2", if4.count); end
    n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bub_head_valid: got %b expected 1", if4.out_valid); end
    if4.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_d = sb.pop_front();
      n_checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== exp_d) begin n_fail++; $display("FAIL bub_adjacent: beat %0d valid %b data %h expected 1 %h", k, if4.out_valid, if4.out_data, exp_d); end
      step();
    end
    n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_empty: got %b expected 0", if4.out_valid); end
  endtask

  task automatic test_flush();
    bit leak;
    idle_all();
    if2.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if2.in_data = 32'h31 + k;
      sb.push_back(if2.in_data);
      step();
    end
    n_checks++; if (if2.count !== 2'd3) begin n_fail++; $display("FAIL fl_count_full: got %0d expected 3", if2.count); end
    if2.flush = 1'b1; if2.in_data = 32'h34; if2.out_ready = 1'b1;
    exp_d = sb.pop_front();
    n_checks++; if (if2.out_valid !== 1'b1 || if2.out_data !== exp_d) begin n_fail++; $display("FAIL fl_head: valid %b data %h expected 1 %h", if2.out_valid, if2.out_data, exp_d); end
    step();
    if2.flush = 1'b0; if2.in_valid = 1'b0;
    sb.delete();
    n_checks++; if (if2.count !== 2'd0) begin n_fail++; $display("FAIL fl_count: got %0d expected 0", if2.count); end
    n_checks++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_out_valid: got %b expected 0", if2.out_valid); end
    n_checks++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b expected 1", if2.in_ready); end
    leak = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (if2.out_valid) leak = 1'b1;
      step();
    end
    n_checks++; if (leak) begin n_fail++; $display("FAIL fl_dropped: got a beat after flush expected none"); end
  endtask

  task automatic test_soak();
    idle_all();
    for (int c = 0; c < 10000; c++) begin
      if2.in_valid  = ($urandom_range(0, 99) < 60);
      if2.in_data   = $urandom();
      if2.out_ready = ($urandom_range(0, 99) < 70);
      if2.flush     = ($urandom_range(0, 99) < 3);
      if (if2.out_valid && if2.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL soak_dup: cycle %0d got %h expected no beat", c, if2.out_data);
        end else begin
          exp_d = sb.pop_front();
          n_checks++; if (if2.out_data !== exp_d) begin n_fail++; $display("FAIL soak_order: cycle %0d got %h expected %h", c, if2.out_data, exp_d); end
        end
      end
      if (if2.flush) sb.delete();
      else if (if2.in_valid && if2.in_ready) sb.push_back(if2.in_data);
      step();
      n_checks++; if (int'(if2.count) != sb.size()) begin n_fail++; $display("FAIL soak_count: cycle %0d got %0d expected %0d", c, if2.count, sb.size()); end
    end
    if2.in_valid = 1'b0; if2.flush = 1'b0; if2.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (if2.out_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL soak_drain_dup: got %h expected no beat", if2.out_data);
        end else begin
          exp_d = sb.pop_front();
          n_checks++; if (if2.out_data !== exp_d) begin n_fail++; $display("FAIL soak_drain_order: got %h expected %h", if2.out_data, exp_d); end
        end
      end
      step();
    end
    n_checks++; if (sb.size() != 0 || if2.count !== 2'd0) begin n_fail++; $display("FAIL soak_loss: %0d beats missing, count %0d expected 0 and 0", sb.size(), if2.count); end
  endtask

  initial begin
    idle_all();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_flush();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
